flag_register_unit: RTL and testbench

- Owns the architectural NZCV flag register in the execute stage.
- Sole source of the `Flags` vector consumed by the condition checker.
- Commits masked ALU flag updates from executed instructions, and tracks one outstanding multi-cycle flag-setting operation (multiplier/divider) until it completes.
- While that operation is in flight it raises a busy signal, so the hazard unit stalls flag-dependent instructions.

---
 rtl/flag_pkg.sv | 29 ++
 rtl/flag_merge.sv | 34 +++
 rtl/flag_register_unit.sv | 141 ++++++++++++++
 tb/tb_flag_register_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_pkg
// Description : Shared types and constants for the NZCV flag register unit.
//               flags_t      - packed {n, z, c, v} flag vector (n is the MSB)
//               FLAGW_NZ     - write-mask bit selecting the N and Z fields
//               FLAGW_CV     - write-mask bit selecting the C and V fields
//               flag_state_t - outstanding multi-cycle write tracker states
// Revision    : 1.0 - initial release
// ============================================================================
package flag_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } flag_state_t;

endpackage
`default_nettype wire

// File: rtl/flag_merge.sv
`default_nettype none
// ============================================================================
// Module      : flag_merge
// Description : Combinational masked merge of a new flag vector over an old
//               one. Fields not selected by the mask keep their old value.
// Ports       : i_old    - current flag vector
//               i_new    - candidate flag vector
//               i_mask   - write mask (FLAGW_NZ selects N,Z; FLAGW_CV selects C,V)
//               o_merged - resulting flag vector
// Revision    : 1.0 - initial release
// ============================================================================
module flag_merge
    import flag_pkg::*;
(
    input  flags_t     i_old,
    input  flags_t     i_new,
    input  logic [1:0] i_mask,
    output flags_t     o_merged
);

    always_comb begin
        o_merged = i_old;
        if ((i_mask & FLAGW_NZ) != 2'b00) begin
            o_merged.n = i_new.n;
            o_merged.z = i_new.z;
        end
        if ((i_mask & FLAGW_CV) != 2'b00) begin
            o_merged.c = i_new.c;
            o_merged.v = i_new.v;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flag_register_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_register_unit
// Description : Architectural NZCV flag register for the execute stage.
//               Commits masked ALU flag updates from executed instructions and
//               tracks one outstanding multi-cycle (mul/div) flag write,
//               raising flags_busy while it is in flight.
// Config      : FLAG_BYPASS_EN - when defined, the mc_done cycle drives Flags
//               combinationally with the merged result and drops flags_busy in
//               that same cycle. When undefined, Flags is purely the register.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               ex_valid, CondEx    - execute-stage instruction valid / cond pass
//               FlagW, ALUFlags     - execute write mask and ALU flags
//               stall, flush        - execute stage held / killed
//               mc_start, mc_flagw  - multi-cycle op issue and its write mask
//               mc_done, mc_flags   - multi-cycle completion and its flags
//               Flags               - current flags to the condition checker
//               flags_busy          - multi-cycle flag write outstanding
//               flag_err            - sticky protocol-violation indicator
// Revision    : 1.0 - initial release
// ============================================================================
module flag_register_unit
    import flag_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              CondEx,
    input  logic [1:0]        FlagW,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic              stall,
    input  logic              flush,
    input  logic              mc_start,
    input  logic [1:0]        mc_flagw,
    input  logic              mc_done,
    input  logic [FLAG_W-1:0] mc_flags,
    output logic [FLAG_W-1:0] Flags,
    output logic              flags_busy,
    output logic              flag_err
);

    flag_state_t r_state_q,     w_state_d;
    flags_t      r_flags_q,     w_flags_d;
    logic [1:0]  r_pend_mask_q, w_pend_mask_d;
    logic        r_err_q,       w_err_d;

    logic        w_ex_go;
    logic        w_mc_commit;
    flags_t      w_ex_merged;
    flags_t      w_mc_merged;

    flag_merge u_ex_merge (
        .i_old    (r_flags_q),
        .i_new    (flags_t'(ALUFlags)),
        .i_mask   (FlagW),
        .o_merged (w_ex_merged)
    );

    flag_merge u_mc_merge (
        .i_old    (r_flags_q),
        .i_new    (flags_t'(mc_flags)),
        .i_mask   (r_pend_mask_q),
        .o_merged (w_mc_merged)
    );

    always_comb begin
        w_ex_go       = ex_valid & CondEx & ~stall & ~flush;
        // Flush cancels the pending op, so it wins over a same-cycle mc_done.
        w_mc_commit   = (r_state_q == PENDING) & mc_done & ~flush;

        w_state_d     = r_state_q;
        w_flags_d     = r_flags_q;
        w_pend_mask_d = r_pend_mask_q;
        w_err_d       = r_err_q;

        case (r_state_q)
            IDLE: begin
                // An execute write alongside mc_start still commits: it is
                // younger than nothing outstanding, and the new op is older
                // than any later flag write.
                if (w_ex_go) begin
                    w_flags_d = w_ex_merged;
                end
                if (mc_start & ~flush) begin
                    w_state_d     = PENDING;
                    w_pend_mask_d = mc_flagw;
                end
                if (mc_done) begin
                    w_err_d = 1'b1;
                end
            end
            PENDING: begin
                // Flag-writing instructions must be held off by the hazard
                // unit while busy; any that slip through are dropped.
                if (w_ex_go & (FlagW != 2'b00)) begin
                    w_err_d = 1'b1;
                end
                if (mc_start & ~flush) begin
                    w_err_d = 1'b1;
                end
                if (flush) begin
                    w_state_d = IDLE;
                end else if (mc_done) begin
                    w_state_d = IDLE;
                    w_flags_d = w_mc_merged;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_flags_q     <= '0;
            r_pend_mask_q <= 2'b00;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_flags_q     <= w_flags_d;
            r_pend_mask_q <= w_pend_mask_d;
            r_err_q       <= w_err_d;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign Flags      = w_mc_commit ? w_mc_merged : r_flags_q;
    assign flags_busy = (r_state_q == PENDING) & ~w_mc_commit;
`else
    assign Flags      = r_flags_q;
    assign flags_busy = (r_state_q == PENDING);
`endif

    assign flag_err = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_register_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_register_unit
// Description : Self-checking bench for flag_register_unit. Directed steps
//               followed by random traffic, compared every cycle against a
//               rule-level reference model of the flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_register_unit;

    logic       clk = 1'b0;
    logic       reset, ex_valid, CondEx, stall, flush, mc_start, mc_done;
    logic [1:0] FlagW, mc_flagw;
    logic [3:0] ALUFlags, mc_flags;
    logic [3:0] Flags;
    logic       flags_busy, flag_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [1:0] m_mask;
    logic       m_pend;
    logic       m_err;
    logic       m_known = 1'b0;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    flag_register_unit #(.FLAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .CondEx     (CondEx),
        .FlagW      (FlagW),
        .ALUFlags   (ALUFlags),
        .stall      (stall),
        .flush      (flush),
        .mc_start   (mc_start),
        .mc_flagw   (mc_flagw),
        .mc_done    (mc_done),
        .mc_flags   (mc_flags),
        .Flags      (Flags),
        .flags_busy (flags_busy),
        .flag_err   (flag_err)
    );

    function automatic logic [3:0] merge(input logic [3:0] old_f, input logic [3:0] new_f,
                                         input logic [1:0] mask);
        logic [3:0] r;
        r = old_f;
        if (mask[1]) r[3:2] = new_f[3:2];
        if (mask[0]) r[1:0] = new_f[1:0];
        return r;
    endfunction

    function automatic logic [3:0] exp_flags();
        if (BYPASS && m_pend && mc_done && !flush) return merge(m_flags, mc_flags, m_mask);
        return m_flags;
    endfunction

    function automatic logic exp_busy();
        if (BYPASS && m_pend && mc_done && !flush) return 1'b0;
        return m_pend;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        if (m_known) begin
            check({tag, ".flags"}, Flags, exp_flags());
            check({tag, ".busy"}, {3'b000, flags_busy}, {3'b000, exp_busy()});
            check({tag, ".err"},  {3'b000, flag_err},   {3'b000, m_err});
        end
    endtask

    // Apply the architectural rules for one clock edge.
    task automatic model_update();
        logic go;
        go = ex_valid && CondEx && !stall && !flush;
        if (reset) begin
            m_flags = 4'b0000;
            m_mask  = 2'b00;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (!m_pend) begin
            if (go) m_flags = merge(m_flags, ALUFlags, FlagW);
            if (mc_done) m_err = 1'b1;
            if (mc_start && !flush) begin
                m_pend = 1'b1;
                m_mask = mc_flagw;
            end
        end else begin
            if (go && FlagW != 2'b00) m_err = 1'b1;
            if (mc_start && !flush) m_err = 1'b1;
            if (flush) begin
                m_pend = 1'b0;
            end else if (mc_done) begin
                m_flags = merge(m_flags, mc_flags, m_mask);
                m_pend  = 1'b0;
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are compared
    // with the model on the falling edge, then the model advances on the edge.
    task automatic step(input string tag);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        ex_valid = 1'b0;
        CondEx   = 1'b0;
        FlagW    = 2'b00;
        ALUFlags = 4'b0000;
        stall    = 1'b0;
        flush    = 1'b0;
        mc_start = 1'b0;
        mc_flagw = 2'b00;
        mc_done  = 1'b0;
        mc_flags = 4'b0000;
    endtask

    initial begin
        idle();
        #1;
        // Reset
        reset = 1'b1;
        step("rst0");
        step("rst1");
        idle(); #1;
        check("reset_flags", Flags, 4'b0000);
        check("reset_busy", {3'b000, flags_busy}, 4'b0000);
        check("reset_err",  {3'b000, flag_err},   4'b0000);

        // Full execute write
        ex_valid = 1'b1; CondEx = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1010;
        step("ex11");
        idle(); #1;
        check("ex11_flags", Flags, 4'b1010);
        check("ex11_busy", {3'b000, flags_busy}, 4'b0000);

        // C,V-only write
        ex_valid = 1'b1; CondEx = 1'b1; FlagW = 2'b01; ALUFlags = 4'b0101;
        step("ex01");
        idle(); #1;
        check("ex01_flags", Flags, 4'b1001);

        // Condition failed: no write
        ex_valid = 1'b1; CondEx = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0110;
        step("condfail");
        idle(); #1;
        check("condfail_flags", Flags, 4'b1001);

        // Multi-cycle op, N,Z mask, three idle cycles then done
        reset = 1'b1;
        step("rst2");
        idle();
        mc_start = 1'b1; mc_flagw = 2'b10;
        step("mc_start");
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mc_wait_busy", {3'b000, flags_busy}, 4'b0001);
            step("mc_wait");
        end
        mc_done = 1'b1; mc_flags = 4'b0110;
        #1;
        check("mc_done_cycle_busy", {3'b000, flags_busy}, BYPASS ? 4'b0000 : 4'b0001);
        check("mc_done_cycle_flags", Flags, BYPASS ? 4'b0100 : 4'b0000);
        step("mc_done");
        idle(); #1;
        check("mc_after_flags", Flags, 4'b0100);
        check("mc_after_busy", {3'b000, flags_busy}, 4'b0000);

        // Flush beats a simultaneous mc_done
        mc_start = 1'b1; mc_flagw = 2'b11;
        step("mc_start2");
        idle();
        mc_done = 1'b1; flush = 1'b1; mc_flags = 4'b1111;
        step("flush_done");
        idle(); #1;
        check("flush_flags", Flags, 4'b0100);
        check("flush_busy", {3'b000, flags_busy}, 4'b0000);
        check("flush_err",  {3'b000, flag_err},   4'b0000);

        // Execute write while pending: dropped, sticky error
        mc_start = 1'b1; mc_flagw = 2'b11;
        step("mc_start3");
        idle();
        ex_valid = 1'b1; CondEx = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
        step("ex_in_pend");
        idle(); #1;
        check("drop_flags", Flags, 4'b0100);
        check("drop_err", {3'b000, flag_err}, 4'b0001);
        for (int i = 0; i < 10; i++) step("err_hold");
        check("err_sticky", {3'b000, flag_err}, 4'b0001);
        check("still_busy", {3'b000, flags_busy}, 4'b0001);
        // Reset mid-pending loses the op and clears the error
        reset = 1'b1;
        step("rst3");
        idle(); #1;
        check("rst_err", {3'b000, flag_err}, 4'b0000);
        check("rst_busy", {3'b000, flags_busy}, 4'b0000);
        check("rst_flags", Flags, 4'b0000);

        // Stall holds the write; it commits once released
        ex_valid = 1'b1; CondEx = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0011; stall = 1'b1;
        step("stalled");
        #1;
        check("stall_flags", Flags, 4'b0000);
        stall = 1'b0;
        step("unstalled");
        idle(); #1;
        check("unstall_flags", Flags, 4'b0011);

        // Random traffic, mostly honouring the hazard contract
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            CondEx   = ($urandom_range(0, 3) != 0);
            FlagW    = 2'($urandom_range(0, 3));
            ALUFlags = 4'($urandom_range(0, 15));
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            mc_start = ($urandom_range(0, 7) == 0);
            mc_flagw = 2'($urandom_range(0, 3));
            mc_done  = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            mc_flags = 4'($urandom_range(0, 15));
            if (m_pend && ($urandom_range(0, 19) != 0)) begin
                FlagW    = 2'b00;
                mc_start = 1'b0;
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
